psram_mem_ctrl: RTL and testbench

- Byte-wide memory controller bridging a simple request bus (chip-select, write flag, 24-bit address, 8-bit data) to two quad-SPI PSRAM chips, U7 on lanes 0-3 and U9 on lanes 4-7, which share one CS and one SCLK.
- After power-up it waits the PSRAM start-up delay, then switches both chips to QPI mode.
- It then serves single-byte writes and reads.

---
 rtl/psram_mem_ctrl.sv | 200 ++++++++++++++++++++
 tb/tb_psram_mem_ctrl.sv | 299 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/psram_mem_ctrl.sv
// ==========================================================================
// psram_mem_ctrl: byte-wide request bus to two lockstepped quad-SPI PSRAMs
// (U7 on lanes 0-3, U9 on lanes 4-7). Rev 1.0
// ==========================================================================
`timescale 1ns/1ps
`default_nettype none

module psram_mem_ctrl #(
  parameter int         initDelayInClkCyles = 15000,
  parameter logic [7:0] CMD_QPI_ENABLE      = 8'h35,
  parameter logic [7:0] CMD_WRITE           = 8'h38,
  parameter logic [7:0] CMD_READ            = 8'hEB,
  parameter int         READ_WAIT_CYCLES    = 6
) (
  input  logic        i_clkRAM,
  input  logic        reset,
  input  logic        i_cs,
  input  logic        i_write,
  input  logic [23:0] addrBus,
  input  logic [7:0]  dataToWrite,
  output logic [7:0]  dataRead,
  inout  wire         io_psram_data0,
  inout  wire         io_psram_data1,
  inout  wire         io_psram_data2,
  inout  wire         io_psram_data3,
  inout  wire         io_psram_data4,
  inout  wire         io_psram_data5,
  inout  wire         io_psram_data6,
  inout  wire         io_psram_data7,
  output logic        o_psram_sclk,
  output logic        o_psram_cs,
  output logic        o_busy,
  output logic        o_dataReady
);

  localparam int         CNT_W     = $clog2(initDelayInClkCyles + 1);
  localparam logic [3:0] WAIT_LAST = 4'(READ_WAIT_CYCLES - 1);

  typedef enum logic [3:0] {
    INIT_1, ENABLE_QPI, IDLE,
    WR_CMD, WR_ADDR, WR_DATA, WR_END,
    RD_CMD, RD_ADDR, RD_WAIT, RD_DATA
  } state_t;

  state_t           state;
  logic [CNT_W-1:0] delayCounter;
  logic [3:0]       step;
  logic [7:0]       cmd_sr;
  logic [23:0]      addr_sr;
  logic [7:0]       wdata;
  logic [3:0]       rd_hi;
  logic [7:0]       lane_out;
  logic [7:0]       lane_oe;

  wire [3:0] rd_nibble = {io_psram_data3, io_psram_data2, io_psram_data1, io_psram_data0};

  assign io_psram_data0 = lane_oe[0] ? lane_out[0] : 1'bz;
  assign io_psram_data1 = lane_oe[1] ? lane_out[1] : 1'bz;
  assign io_psram_data2 = lane_oe[2] ? lane_out[2] : 1'bz;
  assign io_psram_data3 = lane_oe[3] ? lane_out[3] : 1'bz;
  assign io_psram_data4 = lane_oe[4] ? lane_out[4] : 1'bz;
  assign io_psram_data5 = lane_oe[5] ? lane_out[5] : 1'bz;
  assign io_psram_data6 = lane_oe[6] ? lane_out[6] : 1'bz;
  assign io_psram_data7 = lane_oe[7] ? lane_out[7] : 1'bz;

  // Lanes change on the rising edge; the inverted clock gives the PSRAM a mid-cycle sample point.
  assign o_psram_sclk = ~o_psram_cs & ~i_clkRAM;

  always_ff @(posedge i_clkRAM or negedge reset) begin
    if (!reset) begin
      state        <= INIT_1;
      delayCounter <= CNT_W'(initDelayInClkCyles);
      step         <= 4'd0;
      cmd_sr       <= 8'h00;
      addr_sr      <= 24'h0;
      wdata        <= 8'h00;
      rd_hi        <= 4'h0;
      lane_out     <= 8'h00;
      lane_oe      <= 8'h00;
      dataRead     <= 8'h00;
      o_psram_cs   <= 1'b1;
      o_busy       <= 1'b1;
      o_dataReady  <= 1'b0;
    end else begin
      o_dataReady <= 1'b0;
      case (state)
        INIT_1: begin
          if (delayCounter != '0) delayCounter <= delayCounter - 1'b1;
          if (delayCounter <= CNT_W'(1)) begin
            state      <= ENABLE_QPI;
            o_psram_cs <= 1'b0;
            lane_oe    <= 8'h11;
            lane_out   <= {3'b000, CMD_QPI_ENABLE[7], 3'b000, CMD_QPI_ENABLE[7]};
            cmd_sr     <= {CMD_QPI_ENABLE[6:0], 1'b0};
            step       <= 4'd0;
          end
        end
        ENABLE_QPI: begin
          if (step == 4'd7) begin
            state      <= IDLE;
            o_psram_cs <= 1'b1;
            lane_oe    <= 8'h00;
            o_busy     <= 1'b0;
          end else begin
            lane_out <= {3'b000, cmd_sr[7], 3'b000, cmd_sr[7]};
            cmd_sr   <= {cmd_sr[6:0], 1'b0};
            step     <= step + 4'd1;
          end
        end
        IDLE: begin
          if (!i_cs) begin
            o_busy     <= 1'b1;
            o_psram_cs <= 1'b0;
            lane_oe    <= 8'h11;
            addr_sr    <= addrBus;
            wdata      <= dataToWrite;
            step       <= 4'd0;
            if (i_write) begin
              state    <= WR_CMD;
              lane_out <= {3'b000, CMD_WRITE[7], 3'b000, CMD_WRITE[7]};
              cmd_sr   <= {CMD_WRITE[6:0], 1'b0};
            end else begin
              state    <= RD_CMD;
              lane_out <= {3'b000, CMD_READ[7], 3'b000, CMD_READ[7]};
              cmd_sr   <= {CMD_READ[6:0], 1'b0};
            end
          end
        end
        WR_CMD, RD_CMD: begin
          if (step == 4'd7) begin
            state    <= (state == WR_CMD) ? WR_ADDR : RD_ADDR;
            lane_oe  <= 8'hFF;
            lane_out <= {2{addr_sr[23:20]}};
            addr_sr  <= {addr_sr[19:0], 4'h0};
            step     <= 4'd0;
          end else begin
            lane_out <= {3'b000, cmd_sr[7], 3'b000, cmd_sr[7]};
            cmd_sr   <= {cmd_sr[6:0], 1'b0};
            step     <= step + 4'd1;
          end
        end
        WR_ADDR, RD_ADDR: begin
          if (step == 4'd5) begin
            step <= 4'd0;
            if (state == WR_ADDR) begin
              state    <= WR_DATA;
              lane_out <= {2{wdata[7:4]}};
            end else begin
              state   <= RD_WAIT;
              lane_oe <= 8'h00;
            end
          end else begin
            lane_out <= {2{addr_sr[23:20]}};
            addr_sr  <= {addr_sr[19:0], 4'h0};
            step     <= step + 4'd1;
          end
        end
        WR_DATA: begin
          if (step == 4'd0) begin
            lane_out <= {2{wdata[3:0]}};
            step     <= 4'd1;
          end else begin
            state      <= WR_END;
            o_psram_cs <= 1'b1;
            lane_oe    <= 8'h00;
          end
        end
        WR_END: begin
          state  <= IDLE;
          o_busy <= 1'b0;
        end
        RD_WAIT: begin
          if (step == WAIT_LAST) begin
            state <= RD_DATA;
            step  <= 4'd0;
          end else begin
            step <= step + 4'd1;
          end
        end
        RD_DATA: begin
          // Only U7 returns data; U9 lanes are ignored on reads.
          if (step == 4'd0) begin
            rd_hi <= rd_nibble;
            step  <= 4'd1;
          end else begin
            dataRead    <= {rd_hi, rd_nibble};
            o_dataReady <= 1'b1;
            o_psram_cs  <= 1'b1;
            o_busy      <= 1'b0;
            state       <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_psram_mem_ctrl.sv
// Directed bench for psram_mem_ctrl: init, QPI enable, writes, reads with a
// simple U7 responder, held request and mid-transfer reset.
`timescale 1ns/1ps
`default_nettype none

module tb_psram_mem_ctrl;

  logic        clk;
  logic        reset;
  logic        i_cs;
  logic        i_write;
  logic [23:0] addrBus;
  logic [7:0]  dataToWrite;
  logic [7:0]  dataRead;
  wire         io0, io1, io2, io3, io4, io5, io6, io7;
  logic        o_psram_sclk;
  logic        o_psram_cs;
  logic        o_busy;
  logic        o_dataReady;

  logic        m_oe;
  logic [3:0]  m_nib;
  int          checks;
  int          errors;

  assign io0 = m_oe ? m_nib[0] : 1'bz;
  assign io1 = m_oe ? m_nib[1] : 1'bz;
  assign io2 = m_oe ? m_nib[2] : 1'bz;
  assign io3 = m_oe ? m_nib[3] : 1'bz;

  psram_mem_ctrl dut (
    .i_clkRAM       (clk),
    .reset          (reset),
    .i_cs           (i_cs),
    .i_write        (i_write),
    .addrBus        (addrBus),
    .dataToWrite    (dataToWrite),
    .dataRead       (dataRead),
    .io_psram_data0 (io0),
    .io_psram_data1 (io1),
    .io_psram_data2 (io2),
    .io_psram_data3 (io3),
    .io_psram_data4 (io4),
    .io_psram_data5 (io5),
    .io_psram_data6 (io6),
    .io_psram_data7 (io7),
    .o_psram_sclk   (o_psram_sclk),
    .o_psram_cs     (o_psram_cs),
    .o_busy         (o_busy),
    .o_dataReady    (o_dataReady)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached, checks=%0d errors=%0d", checks, errors);
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b0; i_cs = 1'b1; i_write = 1'b0; addrBus = '0; dataToWrite = '0;
    m_oe = 1'b0; m_nib = 4'h0;
    repeat (3) tick();
    checks++;
    if ({o_busy, o_psram_cs, o_dataReady, o_psram_sclk} !== 4'b1100) begin
      errors++;
      $display("FAIL reset_outputs: busy/cs/rdy/sclk got %b want 1100", {o_busy, o_psram_cs, o_dataReady, o_psram_sclk});
    end
    checks++;
    if (dataRead !== 8'h00 || dut.lane_oe !== 8'h00) begin
      errors++;
      $display("FAIL reset_data_lanes: dataRead=%h oe=%b want 00/00000000", dataRead, dut.lane_oe);
    end
    checks++;
    if (dut.delayCounter !== 14'd15000) begin
      errors++;
      $display("FAIL reset_counter: got %0d want 15000", dut.delayCounter);
    end
    reset = 1'b1;
    checks++;
    if (dut.delayCounter !== 14'd15000) begin
      errors++;
      $display("FAIL release_counter0: got %0d want 15000", dut.delayCounter);
    end
    tick();
    checks++;
    if (dut.delayCounter !== 14'd14999) begin
      errors++;
      $display("FAIL release_counter1: got %0d want 14999", dut.delayCounter);
    end
    tick();
    checks++;
    if (dut.delayCounter !== 14'd14998 || o_busy !== 1'b1) begin
      errors++;
      $display("FAIL release_counter2: cnt=%0d busy=%b want 14998/1", dut.delayCounter, o_busy);
    end
  endtask

  // cnt_now is the delay counter value at the current sample point.
  task automatic test_init(input int cnt_now);
    int   n;
    logic busy_drop;
    logic [7:0] cmd;
    logic [7:0] lanes;
    logic [7:0] ev;
    n = 0; busy_drop = 1'b0; cmd = 8'h35;
    while (o_psram_cs === 1'b1 && n < cnt_now + 10) begin
      tick();
      n++;
      if (o_busy !== 1'b1) busy_drop = 1'b1;
    end
    checks++;
    if (n != cnt_now || busy_drop) begin
      errors++;
      $display("FAIL init_delay: cs fell after %0d clocks (busy_drop=%b) want %0d", n, busy_drop, cnt_now);
    end
    for (int k = 0; k < 8; k++) begin
      if (k > 0) tick();
      lanes = {io7, io6, io5, io4, io3, io2, io1, io0};
      ev = {3'b000, cmd[7-k], 3'b000, cmd[7-k]};
      checks++;
      if ({o_psram_cs, o_busy, o_psram_sclk} !== 3'b011 || dut.lane_oe !== 8'h11 || (lanes & 8'h11) !== ev) begin
        errors++;
        $display("FAIL qpi_bit%0d: cs/busy/sclk=%b oe=%b lanes=%b want 011/00010001/%b",
                 k, {o_psram_cs, o_busy, o_psram_sclk}, dut.lane_oe, lanes & 8'h11, ev);
      end
    end
    tick();
    checks++;
    if ({o_psram_cs, o_busy, o_psram_sclk} !== 3'b100 || dut.lane_oe !== 8'h00) begin
      errors++;
      $display("FAIL qpi_idle: cs/busy/sclk=%b oe=%b want 100/00000000", {o_psram_cs, o_busy, o_psram_sclk}, dut.lane_oe);
    end
  endtask

  task automatic test_write(input logic [23:0] a, input logic [7:0] d, input bit hold);
    logic [7:0] cmd;
    logic [7:0] ev;
    logic [7:0] eo;
    logic [7:0] lanes;
    logic       ecs;
    logic       ebusy;
    int         n;
    cmd = 8'h38;
    i_cs = 1'b0; i_write = 1'b1; addrBus = a; dataToWrite = d;
    for (int k = 1; k <= 18; k++) begin
      tick();
      if (k == 1 && !hold) i_cs = 1'b1;
      if (k <= 8) begin
        eo = 8'h11; ev = {3'b000, cmd[8-k], 3'b000, cmd[8-k]};
      end else if (k <= 14) begin
        eo = 8'hFF; ev = {2{a[23-4*(k-9) -: 4]}};
      end else if (k == 15) begin
        eo = 8'hFF; ev = {2{d[7:4]}};
      end else if (k == 16) begin
        eo = 8'hFF; ev = {2{d[3:0]}};
      end else begin
        eo = 8'h00; ev = 8'h00;
      end
      ecs   = (k > 16);
      ebusy = (k <= 17);
      lanes = {io7, io6, io5, io4, io3, io2, io1, io0};
      checks++;
      if ({o_psram_cs, o_busy, o_dataReady, o_psram_sclk} !== {ecs, ebusy, 1'b0, ~ecs}) begin
        errors++;
        $display("FAIL wr_ctrl_c%0d: cs/busy/rdy/sclk=%b want %b", k,
                 {o_psram_cs, o_busy, o_dataReady, o_psram_sclk}, {ecs, ebusy, 1'b0, ~ecs});
      end
      checks++;
      if (dut.lane_oe !== eo || (lanes & eo) !== ev) begin
        errors++;
        $display("FAIL wr_lanes_c%0d: oe=%b lanes=%b want oe=%b lanes=%b", k, dut.lane_oe, lanes & eo, eo, ev);
      end
    end
    if (hold) begin
      tick();
      checks++;
      if (o_psram_cs !== 1'b0 || o_busy !== 1'b1) begin
        errors++;
        $display("FAIL held_cs_restart: cs=%b busy=%b want 0/1", o_psram_cs, o_busy);
      end
      i_cs = 1'b1;
      n = 0;
      while (o_busy === 1'b1 && n < 40) begin
        tick();
        n++;
      end
      checks++;
      if (n != 17) begin
        errors++;
        $display("FAIL held_second_len: busy low after %0d more clocks want 17", n);
      end
    end
  endtask

  task automatic test_read(input logic [23:0] a, input logic [7:0] model_val);
    logic [7:0] cmd;
    logic [7:0] ev;
    logic [7:0] eo;
    logic [7:0] lanes;
    logic       ecs;
    logic       ebusy;
    logic       erdy;
    cmd = 8'hEB;
    i_cs = 1'b0; i_write = 1'b0; addrBus = a; dataToWrite = 8'h00;
    for (int k = 1; k <= 24; k++) begin
      tick();
      if (k == 1) i_cs = 1'b1;
      m_oe  = (k == 21 || k == 22);
      m_nib = (k == 21) ? model_val[7:4] : model_val[3:0];
      if (k <= 8) begin
        eo = 8'h11; ev = {3'b000, cmd[8-k], 3'b000, cmd[8-k]};
      end else if (k <= 14) begin
        eo = 8'hFF; ev = {2{a[23-4*(k-9) -: 4]}};
      end else begin
        eo = 8'h00; ev = 8'h00;
      end
      ecs   = (k > 22);
      ebusy = (k <= 22);
      erdy  = (k == 23);
      lanes = {io7, io6, io5, io4, io3, io2, io1, io0};
      checks++;
      if ({o_psram_cs, o_busy, o_dataReady, o_psram_sclk} !== {ecs, ebusy, erdy, ~ecs}) begin
        errors++;
        $display("FAIL rd_ctrl_c%0d: cs/busy/rdy/sclk=%b want %b", k,
                 {o_psram_cs, o_busy, o_dataReady, o_psram_sclk}, {ecs, ebusy, erdy, ~ecs});
      end
      checks++;
      if (dut.lane_oe !== eo || (lanes & eo) !== ev) begin
        errors++;
        $display("FAIL rd_lanes_c%0d: oe=%b lanes=%b want oe=%b lanes=%b", k, dut.lane_oe, lanes & eo, eo, ev);
      end
      if (k >= 23) begin
        checks++;
        if (dataRead !== model_val) begin
          errors++;
          $display("FAIL rd_data_c%0d: dataRead=%h want %h", k, dataRead, model_val);
        end
      end
    end
  endtask

  task automatic test_back_to_back();
    test_write(24'h123456, 8'h3C, 1'b1);
  endtask

  task automatic test_reset_mid_write();
    i_cs = 1'b0; i_write = 1'b1; addrBus = 24'hABCDEF; dataToWrite = 8'h77;
    repeat (10) begin
      tick();
      i_cs = 1'b1;
    end
    checks++;
    if (o_psram_cs !== 1'b0 || dut.lane_oe !== 8'hFF) begin
      errors++;
      $display("FAIL midwr_active: cs=%b oe=%b want 0/11111111", o_psram_cs, dut.lane_oe);
    end
    #2 reset = 1'b0;
    #1;
    checks++;
    if ({o_busy, o_psram_cs, o_dataReady, o_psram_sclk} !== 4'b1100 || dut.lane_oe !== 8'h00) begin
      errors++;
      $display("FAIL midwr_abort: busy/cs/rdy/sclk=%b oe=%b want 1100/00000000",
               {o_busy, o_psram_cs, o_dataReady, o_psram_sclk}, dut.lane_oe);
    end
    checks++;
    if (dut.delayCounter !== 14'd15000) begin
      errors++;
      $display("FAIL midwr_counter: got %0d want 15000", dut.delayCounter);
    end
    tick();
    reset = 1'b1;
    test_init(15000);
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_init(14998);
    test_write(24'h00C000, 8'hAA, 1'b0);
    test_read(24'h00C000, 8'h5C);
    test_read(24'hFEDCBA, 8'hA3);
    test_back_to_back();
    test_reset_mid_write();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
